ula_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle ULA in the MIPS datapath. It executes the R-type logic, arithmetic and shift ops in one registered cycle. It adds iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MFHI/MFLO readout. Operand width is set by `WIDTH`, and a start/busy/done handshake lets the control unit stall the pipeline while a long operation runs.

---
 rtl/ula_mc.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ula_mc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_mc.sv
// ----------------------------------------------------------------------------
// ula_mc : multi-cycle ALU for the MIPS datapath.
//
// Executes the R-type logic/arithmetic/shift ops in one registered cycle and
// runs MULT/MULTU (and DIV/DIVU when ULA_DIV_EN is defined) iteratively, one
// bit per cycle, into the HI/LO register pair. MFHI/MFLO read HI/LO back out
// through Result. A start/busy/done handshake lets the control unit stall.
//
// Configuration macro: ULA_DIV_EN
//    defined   -> restoring divider present, DIV/DIVU execute over WIDTH cycles
//    undefined -> no divider logic, DIV/DIVU codes behave like invalid ops
//
// Ports:
//    clk        rising-edge clock
//    reset      synchronous, active-high
//    start      operation request, only honoured while idle
//    In1        operand 1 (rs, dividend / multiplicand, shift source)
//    In2        operand 2 (rt, divisor / multiplier, shift amount in low bits)
//    OP         5-bit operation code, sampled together with start
//    busy       high while an accepted operation is running or completing
//    done       one-cycle pulse when Result/HI/LO are valid
//    Result     registered result, held until the next accepted operation
//    Zero_flag  registered (Result == 0), updated together with Result
//    HI, LO     high/low product or remainder/quotient registers
// ----------------------------------------------------------------------------
module ula_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [4:0]       OP,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero_flag,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [4:0] OP_AND   = 5'b00000;
   localparam logic [4:0] OP_OR    = 5'b00001;
   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_XOR   = 5'b00011;
   localparam logic [4:0] OP_NOR   = 5'b00100;
   localparam logic [4:0] OP_SLT   = 5'b00101;
   localparam logic [4:0] OP_SUB   = 5'b00110;
   localparam logic [4:0] OP_SLTU  = 5'b00111;
   localparam logic [4:0] OP_SLL   = 5'b01000;
   localparam logic [4:0] OP_SRL   = 5'b01001;
   localparam logic [4:0] OP_SRA   = 5'b01010;
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
`ifdef ULA_DIV_EN
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;
`endif
   localparam logic [4:0] OP_MFHI  = 5'b10100;
   localparam logic [4:0] OP_MFLO  = 5'b10101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic               accept;
   logic               op_is_mult;
   logic               op_is_div;
   logic               op_multi;
   logic               op_signed;
   logic               in1_neg;
   logic               in2_neg;
   logic [WIDTH-1:0]   in1_mag;
   logic [WIDTH-1:0]   in2_mag;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   alu_res;

   // Iteration state: acc_q holds {partial product, multiplier} for a multiply
   // or {partial remainder, dividend/quotient} for a divide; opnd_q holds the
   // multiplicand or divisor magnitude.
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [CW-1:0]      cnt;
   logic               neg_res_q;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] fin_prod;
   logic [WIDTH-1:0]   fin_hi;
   logic [WIDTH-1:0]   fin_lo;

`ifdef ULA_DIV_EN
   logic               mode_div_q;
   logic               neg_rem_q;
   logic               div_zero_q;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
`endif

   assign accept = (state_q == IDLE) && start;
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign shamt  = In2[SHW-1:0];

   // Operation class decode. Without the divider the DIV codes are simply not
   // recognised and fall through to the invalid-op path of the ALU.
   always_comb begin
      op_is_mult = (OP == OP_MULT) || (OP == OP_MULTU);
      op_is_div  = 1'b0;
      op_signed  = (OP == OP_MULT);
`ifdef ULA_DIV_EN
      op_is_div  = (OP == OP_DIV) || (OP == OP_DIVU);
      op_signed  = (OP == OP_MULT) || (OP == OP_DIV);
`endif
      op_multi   = op_is_mult || op_is_div;
   end

   // Both iterative units work on magnitudes; the signs are remembered and
   // applied to the result on the final iteration.
   always_comb begin
      in1_neg = op_signed && In1[WIDTH-1];
      in2_neg = op_signed && In2[WIDTH-1];
      in1_mag = in1_neg ? -In1 : In1;
      in2_mag = in2_neg ? -In2 : In2;
   end

   // Single-cycle ALU. Unknown codes (and DIV codes without the divider)
   // produce zero. MFHI/MFLO read the current HI/LO registers.
   always_comb begin
      alu_res = '0;
      case (OP)
         OP_AND:  alu_res = In1 & In2;
         OP_OR:   alu_res = In1 | In2;
         OP_ADD:  alu_res = In1 + In2;
         OP_XOR:  alu_res = In1 ^ In2;
         OP_NOR:  alu_res = ~(In1 | In2);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
         OP_SUB:  alu_res = In1 - In2;
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
         OP_SLL:  alu_res = In1 << shamt;
         OP_SRL:  alu_res = In1 >> shamt;
         OP_SRA:  alu_res = $signed(In1) >>> shamt;
         OP_MFHI: alu_res = HI;
         OP_MFLO: alu_res = LO;
         default: alu_res = '0;
      endcase
   end

   // One shift-add multiply step: conditionally add the multiplicand into the
   // upper half, then shift the whole accumulator right, carry included.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

`ifdef ULA_DIV_EN
   // One restoring divide step: shift the next dividend bit into the partial
   // remainder, keep the difference only if it did not borrow. A zero divisor
   // never borrows, which naturally yields all-ones quotient and remainder
   // equal to the dividend magnitude.
   always_comb begin
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
      if (!div_diff[WIDTH+1]) begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   assign quot = acc_next[WIDTH-1:0];
   assign rem  = acc_next[2*WIDTH-1:WIDTH];
`endif

   always_comb begin
      acc_next = mul_next;
`ifdef ULA_DIV_EN
      if (mode_div_q) begin
         acc_next = div_next;
      end
`endif
   end

   // Sign fix-up of the final iteration. Quotient truncates toward zero and
   // the remainder follows the dividend; MIN / -1 wraps back to MIN with a
   // zero remainder without special handling. Only divide-by-zero needs an
   // override so that a signed dividend does not flip the all-ones quotient.
   always_comb begin
      fin_prod = neg_res_q ? -acc_next : acc_next;
      fin_hi   = fin_prod[2*WIDTH-1:WIDTH];
      fin_lo   = fin_prod[WIDTH-1:0];
`ifdef ULA_DIV_EN
      if (mode_div_q) begin
         fin_lo = div_zero_q ? '1 : (neg_res_q ? -quot : quot);
         fin_hi = neg_rem_q ? -rem : rem;
      end
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: single-cycle ops go straight to DONE, iterative ops
   // spend WIDTH cycles in RUN, DONE always lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = op_multi ? RUN : DONE;
            end
         end
         RUN: begin
            if (cnt == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers. Operands are captured on the accepting edge so the
   // inputs are free to change while an iterative op is running.
   always_ff @(posedge clk) begin
      if (reset) begin
         Result    <= '0;
         Zero_flag <= 1'b0;
         HI        <= '0;
         LO        <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt       <= '0;
         neg_res_q <= 1'b0;
`ifdef ULA_DIV_EN
         mode_div_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
`endif
      end else if (accept) begin
         if (op_multi) begin
            cnt       <= CW'(WIDTH);
            neg_res_q <= in1_neg ^ in2_neg;
            acc_q     <= {{WIDTH{1'b0}}, in2_mag};
            opnd_q    <= in1_mag;
`ifdef ULA_DIV_EN
            mode_div_q <= op_is_div;
            neg_rem_q  <= in1_neg;
            div_zero_q <= (In2 == '0);
            if (op_is_div) begin
               acc_q  <= {{WIDTH{1'b0}}, in1_mag};
               opnd_q <= in2_mag;
            end
`endif
         end else begin
            Result    <= alu_res;
            Zero_flag <= (alu_res == '0);
         end
      end else if (state_q == RUN) begin
         acc_q <= acc_next;
         cnt   <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            HI        <= fin_hi;
            LO        <= fin_lo;
            Result    <= fin_lo;
            Zero_flag <= (fin_lo == '0);
         end
      end
   end

endmodule

// File: tb/tb_ula_mc.sv
// ----------------------------------------------------------------------------
// tb_ula_mc : scoreboard testbench for ula_mc (WIDTH = 32).
//
// applyStimulus drives one operation and pushes its hand-computed expected
// response; the monitor pops and compares whenever done is seen. Divider
// expectations follow ULA_DIV_EN so the bench suits either build.
// ----------------------------------------------------------------------------
module tb_ula_mc;

   localparam int WIDTH = 32;

   localparam logic [4:0] OP_AND   = 5'b00000;
   localparam logic [4:0] OP_OR    = 5'b00001;
   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_XOR   = 5'b00011;
   localparam logic [4:0] OP_NOR   = 5'b00100;
   localparam logic [4:0] OP_SLT   = 5'b00101;
   localparam logic [4:0] OP_SUB   = 5'b00110;
   localparam logic [4:0] OP_SLTU  = 5'b00111;
   localparam logic [4:0] OP_SLL   = 5'b01000;
   localparam logic [4:0] OP_SRL   = 5'b01001;
   localparam logic [4:0] OP_SRA   = 5'b01010;
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;
   localparam logic [4:0] OP_MFHI  = 5'b10100;
   localparam logic [4:0] OP_MFLO  = 5'b10101;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        z;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] In1 = '0;
   logic [31:0] In2 = '0;
   logic [4:0]  OP = '0;
   logic        busy;
   logic        done;
   logic [31:0] Result;
   logic        Zero_flag;
   logic [31:0] HI;
   logic [31:0] LO;

   int   n_vec = 0;
   int   n_miss = 0;
   int   edge_cnt = 0;
   exp_t sb_q[$];
   string name_q[$];

   ula_mc #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .In1       (In1),
      .In2       (In2),
      .OP        (OP),
      .busy      (busy),
      .done      (done),
      .Result    (Result),
      .Zero_flag (Zero_flag),
      .HI        (HI),
      .LO        (LO)
   );

   // Free-running clock and a count of rising edges used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t  e;
      string nm;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checkOutput("spurious_done", {63'b0, done}, 64'd0);
         end else begin
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            checkOutput({nm, "_result"}, {32'b0, Result}, {32'b0, e.res});
            checkOutput({nm, "_zero"}, {63'b0, Zero_flag}, {63'b0, e.z});
            checkOutput({nm, "_hi"}, {32'b0, HI}, {32'b0, e.hi});
            checkOutput({nm, "_lo"}, {32'b0, LO}, {32'b0, e.lo});
            checkOutput({nm, "_latency"}, 64'(edge_cnt - e.t0), 64'(e.lat));
         end
      end
   end

   // Drives one op just after a falling edge; afterwards the operand pins are
   // scrambled so that the design must rely on its latched copies.
   task automatic applyStimulus(input string name, input logic [4:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic push_exp,
                                input logic [31:0] eres, input logic ez,
                                input logic [31:0] ehi, input logic [31:0] elo,
                                input int elat);
      exp_t e;
      OP    = op;
      In1   = a;
      In2   = b;
      start = 1'b1;
      if (push_exp) begin
         e.res = eres;
         e.z   = ez;
         e.hi  = ehi;
         e.lo  = elo;
         e.lat = elat;
         e.t0  = edge_cnt;
         sb_q.push_back(e);
         name_q.push_back(name);
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      OP    = OP_AND;
      In1   = 32'hDEADBEEF;
      In2   = 32'h0BADF00D;
   endtask

   task automatic waitIdle(input string name);
      int k = 0;
      while ((busy !== 1'b0 || sb_q.size() != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) begin
         checkOutput({name, "_timeout"}, 64'd1, 64'd0);
      end
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, "_busy"}, {63'b0, busy}, 64'd0);
      checkOutput({name, "_done"}, {63'b0, done}, 64'd0);
      checkOutput({name, "_result"}, {32'b0, Result}, 64'd0);
      checkOutput({name, "_zero"}, {63'b0, Zero_flag}, 64'd0);
      checkOutput({name, "_hi"}, {32'b0, HI}, 64'd0);
      checkOutput({name, "_lo"}, {32'b0, LO}, 64'd0);
   endtask

   task automatic runOne(input string name, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eres, input logic ez,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat);
      applyStimulus(name, op, a, b, 1'b1, eres, ez, ehi, elo, elat);
      waitIdle(name);
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int low_cnt;
      logic [31:0] hi_now;
      logic [31:0] lo_now;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkResetState("reset");

      // Single-cycle ops: Result visible one edge after the driving edge.
      runOne("slt_neg1",   OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 32'h0, 32'h0, 1);
      runOne("sltu_big",   OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 32'h0, 32'h0, 1);
      runOne("add_ovf",    OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 32'h0, 32'h0, 1);
      runOne("add_wrap",   OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 32'h0, 32'h0, 1);
      runOne("sub_wrap",   OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1);
      runOne("and",        OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 32'h0, 32'h0, 1);
      runOne("or",         OP_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1);
      runOne("xor",        OP_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 32'h0, 32'h0, 1);
      runOne("nor",        OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1);
      runOne("sll_31",     OP_SLL,  32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h0, 32'h0, 1);
      runOne("srl_4",      OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 32'h0, 32'h0, 1);
      runOne("sra_4",      OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 32'h0, 32'h0, 1);

      // MULT -3 x 5 with busy sampled on every cycle until done.
      applyStimulus("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'h00000005, 1'b1,
                    32'hFFFFFFF1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 33);
      low_cnt = 0;
      for (int i = 0; i < 33; i++) begin
         if (busy !== 1'b1) low_cnt++;
         if (i < 32) @(negedge clk);
      end
      checkOutput("mult_busy_low_cycles", 64'(low_cnt), 64'd0);
      waitIdle("mult_m3x5");

      runOne("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33);

`ifdef ULA_DIV_EN
      runOne("divu_100_7",  OP_DIVU, 32'd100,      32'd7,        32'h0000000E, 1'b0, 32'h00000002, 32'h0000000E, 33);
      runOne("div_m7_2",    OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      runOne("div_min_m1",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h00000000, 32'h80000000, 33);
      runOne("div_m7_0",    OP_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33);
      runOne("divu_5_0",    OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 32'h00000005, 32'hFFFFFFFF, 33);
      hi_now = 32'h00000005;
      lo_now = 32'hFFFFFFFF;
`else
      runOne("divu_absent", OP_DIVU, 32'd100,      32'd7,        32'h00000000, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1);
      hi_now = 32'hFFFFFFFE;
      lo_now = 32'h00000001;
`endif
      runOne("mfhi", OP_MFHI, 32'h0, 32'h0, hi_now, 1'b0, hi_now, lo_now, 1);
      runOne("mflo", OP_MFLO, 32'h0, 32'h0, lo_now, 1'b0, hi_now, lo_now, 1);

      runOne("mult_min_m1", OP_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h00000000, 32'h80000000, 33);
      runOne("invalid_op",  5'b11111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 32'h00000000, 32'h80000000, 1);

      // Abort: MULTU started, ADD pulsed mid-run is dropped, reset mid-run
      // kills the op without a done pulse and clears everything.
      applyStimulus("multu_abort", OP_MULTU, 32'd3, 32'd4, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);
      repeat (9) @(negedge clk);
      OP    = OP_ADD;
      In1   = 32'd2;
      In2   = 32'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("abort_busy_before_reset", {63'b0, busy}, 64'd1);
      checkOutput("abort_result_before_reset", {32'b0, Result}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkResetState("abort");
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", {63'b0, done}, 64'd0);

      runOne("add_after_abort", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 32'h0, 32'h0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
